// File: rtl/mipi_rx_link_ctrl_if.sv
// Capture handshake between the host and mipi_rx_link_ctrl.
//   capture_req    host -> ctrl  level request to capture frames
//   capture_frames host -> ctrl  number of frames to capture, latched on ack
//   capture_ack    ctrl -> host  1-cycle pulse, request accepted
//   busy           ctrl -> host  capture armed or in progress
//   done           ctrl -> host  1-cycle pulse, last requested frame completed
interface mipi_rx_link_ctrl_if;
  logic       capture_req;
  logic [7:0] capture_frames;
  logic       capture_ack;
  logic       busy;
  logic       done;

  modport master (
    output capture_req,
    output capture_frames,
    input  capture_ack,
    input  busy,
    input  done
  );

  modport slave (
    input  capture_req,
    input  capture_frames,
    output capture_ack,
    output busy,
    output done
  );
endinterface

// File: rtl/mipi_rx_link_ctrl.sv
// Pixel-clock-domain controller for the 2-lane CSI-2 D-PHY RX -> byte2pixel path.
// Brings the path up (drives its reset, waits for frames, re-resets on frame loss),
// checks frame geometry and gates whole frames to the downstream histogram on request.
//
// Optional feature macro: LINK_FRAME_CHECK_EN builds the geometry checker; without it
// frame_err_o and err_cnt_o are tied to 0.
//
// Ports:
//   clk_pixel_i, reset_n_i  pixel clock, asynchronous active-low reset
//   enable_i, pll_lock_i    run request and pixel PLL lock
//   fv_i, lv_i              frame/line valid from byte2pixel
//   cap_io                  capture handshake (slave side)
//   rx_reset_n_o            active-low reset to D-PHY RX / byte2pixel
//   fv_o, lv_o              gated, registered fv/lv
//   link_up_o, fail_o       state == LINKED / FAIL
//   frame_err_o, err_cnt_o  geometry error pulse and saturating count
//   state_o                 IDLE=0, RST_HOLD=1, WAIT_FRAME=2, LINKED=3, FAIL=4
module mipi_rx_link_ctrl #(
  parameter int unsigned EXP_PIXELS   = 640,
  parameter int unsigned EXP_LINES    = 480,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned RST_HOLD_CYC = 64,
  parameter int unsigned TIMEOUT_CYC  = 4194304,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic               clk_pixel_i,
  input  logic               reset_n_i,
  input  logic               enable_i,
  input  logic               pll_lock_i,
  input  logic               fv_i,
  input  logic               lv_i,
  mipi_rx_link_ctrl_if.slave cap_io,
  output logic               rx_reset_n_o,
  output logic               fv_o,
  output logic               lv_o,
  output logic               link_up_o,
  output logic               fail_o,
  output logic               frame_err_o,
  output logic [7:0]         err_cnt_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRstHold   = 3'd1,
    StWaitFrame = 3'd2,
    StLinked    = 3'd3,
    StFail      = 3'd4
  } state_e;

  localparam int unsigned HoldW  = $clog2(RST_HOLD_CYC + 1);
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  localparam logic [HoldW-1:0]  HoldLast = HoldW'(RST_HOLD_CYC - 1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  // Input registers; all edge detection works on the registered copy.
  logic fv_q, lv_q, fv_prev_q;
  logic fv_rise, fv_fall;

  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      fv_prev_q <= 1'b0;
    end else begin
      fv_q      <= fv_i;
      lv_q      <= lv_i;
      fv_prev_q <= fv_q;
    end
  end

  assign fv_rise = fv_q & ~fv_prev_q;
  assign fv_fall = ~fv_q & fv_prev_q;

  // ---------------------------------------------------------------------------
  // Link bring-up FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      retry_q    <= retry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    tmo_cnt_d  = tmo_cnt_q;
    retry_d    = retry_q;
    unique case (state_q)
      StIdle: begin
        retry_d = '0;
        if (enable_i && pll_lock_i) state_d = StRstHold;
      end
      StRstHold: begin
        tmo_cnt_d = '0;
        if (hold_cnt_q == HoldLast) state_d = StWaitFrame;
        else                        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      StWaitFrame: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (fv_rise) begin
          state_d   = StLinked;
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            state_d = StRstHold;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      StLinked: begin
        retry_d   = '0;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (fv_rise) begin
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = StRstHold;
          retry_d = RetryW'(1);
        end
      end
      StFail: begin
        if (!enable_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Losing enable or PLL lock wins over every other transition.
    if (!enable_i || !pll_lock_i) state_d = StIdle;
  end

  assign rx_reset_n_o = (state_q == StWaitFrame) || (state_q == StLinked);
  assign link_up_o    = (state_q == StLinked);
  assign fail_o       = (state_q == StFail);
  assign state_o      = state_q;

  // ---------------------------------------------------------------------------
  // Capture gate
  // ---------------------------------------------------------------------------
  logic       busy_q, busy_d;
  logic       gate_q, gate_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic [7:0] n_q, n_d;
  logic       linked, stay_linked, accept, gate_on;

  assign linked      = (state_q == StLinked);
  assign stay_linked = (state_d == StLinked);
  assign accept      = linked && !busy_q && cap_io.capture_req && (cap_io.capture_frames != 8'd0);
  // The gate takes effect in the fv rise cycle itself so fv_o tracks the registered fv.
  assign gate_on     = linked && busy_q && (gate_q || fv_rise);

  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q <= 1'b0;
      gate_q <= 1'b0;
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      n_q    <= '0;
    end else begin
      busy_q <= busy_d;
      gate_q <= gate_d;
      ack_q  <= ack_d;
      done_q <= done_d;
      n_q    <= n_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    gate_d = gate_q;
    n_d    = n_q;
    ack_d  = 1'b0;
    done_d = 1'b0;
    if (!stay_linked) begin
      // Abandon the capture silently when the link drops.
      busy_d = 1'b0;
      gate_d = 1'b0;
    end else if (gate_q && fv_fall) begin
      n_d = n_q - 8'd1;
      if (n_q == 8'd1) begin
        gate_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0 | 1'b1;
      end
    end else if (busy_q && fv_rise) begin
      gate_d = 1'b1;
    end else if (accept) begin
      ack_d  = 1'b1;
      busy_d = 1'b1;
      n_d    = cap_io.capture_frames;
    end
  end

  assign cap_io.capture_ack = ack_q;
  assign cap_io.busy        = busy_q;
  assign cap_io.done        = done_q;
  assign fv_o               = fv_q & gate_on;
  assign lv_o               = lv_q & gate_on;

  // ---------------------------------------------------------------------------
  // Frame geometry checker
  // ---------------------------------------------------------------------------
`ifdef LINK_FRAME_CHECK_EN
  localparam logic [CNT_W-1:0] PixExp  = CNT_W'(EXP_PIXELS);
  localparam logic [CNT_W-1:0] LineExp = CNT_W'(EXP_LINES);

  logic             lv_prev_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             line_bad_q, line_bad_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             lv_rise, lv_fall, bad_line_now;

  assign lv_rise      = lv_q & ~lv_prev_q;
  assign lv_fall      = ~lv_q & lv_prev_q;
  assign bad_line_now = lv_fall && (pix_cnt_q != PixExp);

  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lv_prev_q   <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_bad_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      lv_prev_q   <= lv_q;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_bad_q  <= line_bad_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_bad_d  = line_bad_q | bad_line_now;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    // The lv rise cycle is the first counted pixel of the line.
    if (lv_rise)                          pix_cnt_d = CNT_W'(1);
    else if (fv_rise)                     pix_cnt_d = '0;
    else if (lv_q && (pix_cnt_q != '1))   pix_cnt_d = pix_cnt_q + 1'b1;
    if (fv_rise) begin
      line_cnt_d = lv_rise ? CNT_W'(1) : '0;
      line_bad_d = 1'b0;
    end else if (lv_rise && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end
    // A line ending in the same cycle as the frame is still judged.
    if (fv_fall && ((line_cnt_q != LineExp) || line_bad_q || bad_line_now)) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign frame_err_o = frame_err_q;
  assign err_cnt_o   = err_cnt_q;
`else
  logic unused_geom_cfg;
  assign unused_geom_cfg = ^{CNT_W[0], EXP_PIXELS[0], EXP_LINES[0]};
  assign frame_err_o     = 1'b0;
  assign err_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_mipi_rx_link_ctrl.sv
module tb_mipi_rx_link_ctrl;
  localparam int EXP_PIX = 16;
  localparam int EXP_LN  = 8;
  localparam int HOLD    = 64;
  localparam int TMO     = 1000;
  localparam int RETRIES = 7;
`ifdef LINK_FRAME_CHECK_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pll = 1'b0;
  logic       fv = 1'b0;
  logic       lv = 1'b0;
  logic       rx_rst_n, fv_out, lv_out, link_up, fail, frame_err;
  logic [7:0] err_cnt;
  logic [2:0] state;

  mipi_rx_link_ctrl_if cap_io ();

  mipi_rx_link_ctrl #(
    .EXP_PIXELS  (EXP_PIX),
    .EXP_LINES   (EXP_LN),
    .CNT_W       (12),
    .RST_HOLD_CYC(HOLD),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (RETRIES)
  ) dut (
    .clk_pixel_i (clk),
    .reset_n_i   (rst_n),
    .enable_i    (enable),
    .pll_lock_i  (pll),
    .fv_i        (fv),
    .lv_i        (lv),
    .cap_io      (cap_io),
    .rx_reset_n_o(rx_rst_n),
    .fv_o        (fv_out),
    .lv_o        (lv_out),
    .link_up_o   (link_up),
    .fail_o      (fail),
    .frame_err_o (frame_err),
    .err_cnt_o   (err_cnt),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int ack_cnt = 0, done_cnt = 0, ferr_cnt = 0, fvo_rise_cnt = 0, lvo_hi = 0;
  int last_done_cyc = 0, last_fvo_rise_cyc = 0;
  logic fvo_prev = 1'b0;
  int exp_err = 0;
  int f_lv[2], f_rise[2], f_fall[2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    fvo_prev <= fv_out;
    if (cap_io.capture_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (lv_out === 1'b1) lvo_hi <= lvo_hi + 1;
    if (fv_out === 1'b1 && fvo_prev !== 1'b1) begin
      fvo_rise_cnt      <= fvo_rise_cnt + 1;
      last_fvo_rise_cyc <= cyc;
    end
    if (cap_io.done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference rule: a frame is bad if its line count or any line length is off.
  function automatic bit frame_bad(input int lines, input int bad_idx, input int bad_len);
    return (lines != EXP_LN) || (bad_idx >= 0 && bad_idx < lines && bad_len != EXP_PIX);
  endfunction

  task automatic send_frame(input int lines, input int bad_idx, input int bad_len,
                            output int lv_cyc, output int rise_c, output int fall_c);
    int gap, len, tail;
    lv_cyc = 0;
    fv = 1'b1;
    rise_c = cyc;
    for (int l = 0; l < lines; l++) begin
      len = (l == bad_idx) ? bad_len : EXP_PIX;
      gap = (l == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      lv = 1'b0;
      if (gap > 0) step(gap);
      lv = 1'b1;
      step(len);
      lv_cyc += len;
    end
    tail = int'($urandom_range(0, 2));
    lv = 1'b0;
    if (tail > 0) step(tail);
    fv = 1'b0;
    fall_c = cyc;
    step(int'($urandom_range(8, 20)));
  endtask

  task automatic request(input int n, output bit got);
    got = 1'b0;
    cap_io.capture_frames = 8'(n);
    cap_io.capture_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1);
      if (cap_io.capture_ack === 1'b1) got = 1'b1;
    end
    cap_io.capture_req = 1'b0;
  endtask

  task automatic test_reset;
    int low;
    bit seen_wait;
    rst_n = 1'b0; enable = 1'b1; pll = 1'b1;
    cap_io.capture_req = 1'b0; cap_io.capture_frames = 8'd0;
    step(3);
    n_tests++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d required 0", state);
    end
    n_tests++;
    if ({rx_rst_n, fv_out, lv_out, link_up, fail, frame_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {rx_rst_n, fv_out, lv_out, link_up, fail, frame_err});
    end
    n_tests++;
    if ({err_cnt, cap_io.capture_ack, cap_io.busy, cap_io.done} !== 11'b0) begin
      n_fail++; $display("FAIL reset_capture: got %b required 0",
                         {err_cnt, cap_io.capture_ack, cap_io.busy, cap_io.done});
    end
    rst_n = 1'b1;
    low = 0; seen_wait = 1'b0;
    for (int i = 0; i < 300 && !seen_wait; i++) begin
      step(1);
      if (state === 3'd1 && rx_rst_n === 1'b0) low++;
      if (state === 3'd2) seen_wait = 1'b1;
    end
    n_tests++;
    if (!seen_wait) begin
      n_fail++; $display("FAIL bringup_wait: got state %0d required 2", state);
    end
    n_tests++;
    if (low != HOLD) begin
      n_fail++; $display("FAIL rst_hold_len: got %0d required %0d", low, HOLD);
    end
    n_tests++;
    if (rx_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL rx_reset_release: got %b required 1", rx_rst_n);
    end
  endtask

  task automatic test_link;
    int a, b, c;
    send_frame(EXP_LN, -1, 0, a, b, c);
    n_tests++;
    if (state !== 3'd3 || link_up !== 1'b1) begin
      n_fail++; $display("FAIL link_up: got state %0d link %b required 3/1", state, link_up);
    end
    n_tests++;
    if (err_cnt !== 8'd0 || ferr_cnt != 0) begin
      n_fail++; $display("FAIL link_err: got %0d/%0d required 0/0", err_cnt, ferr_cnt);
    end
  endtask

  task automatic test_capture_basic;
    bit got;
    int ack0, done0, rise0, lvo0, sum_lv, l, r, f, fall3;
    ack0 = ack_cnt; done0 = done_cnt; rise0 = fvo_rise_cnt; lvo0 = lvo_hi;
    request(3, got);
    step(2);
    n_tests++;
    if (!got || ack_cnt - ack0 != 1) begin
      n_fail++; $display("FAIL cap_ack: got %0d ack cycles required 1", ack_cnt - ack0);
    end
    n_tests++;
    if (cap_io.busy !== 1'b1) begin
      n_fail++; $display("FAIL cap_busy: got %b required 1", cap_io.busy);
    end
    sum_lv = 0; fall3 = 0;
    for (int k = 0; k < 4; k++) begin
      send_frame(EXP_LN, -1, 0, l, r, f);
      if (k < 3) sum_lv += l;
      if (k == 2) fall3 = f;
    end
    n_tests++;
    if (fvo_rise_cnt - rise0 != 3) begin
      n_fail++; $display("FAIL cap_frames: got %0d required 3", fvo_rise_cnt - rise0);
    end
    n_tests++;
    if (done_cnt - done0 != 1 || last_done_cyc - fall3 < 1 || last_done_cyc - fall3 > 2) begin
      n_fail++; $display("FAIL cap_done: got %0d pulses at +%0d required 1 at +1..2",
                         done_cnt - done0, last_done_cyc - fall3);
    end
    n_tests++;
    if (lvo_hi - lvo0 != sum_lv) begin
      n_fail++; $display("FAIL cap_lv: got %0d required %0d", lvo_hi - lvo0, sum_lv);
    end
    n_tests++;
    if (cap_io.busy !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL cap_end: got busy %b err %0d required 0/0", cap_io.busy, err_cnt);
    end
  endtask

  task automatic test_zero_frames;
    int ack0;
    ack0 = ack_cnt;
    cap_io.capture_frames = 8'd0;
    cap_io.capture_req = 1'b1;
    step(20);
    cap_io.capture_req = 1'b0;
    n_tests++;
    if (ack_cnt != ack0 || cap_io.busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_frames: got ack %0d busy %b required 0/0",
                         ack_cnt - ack0, cap_io.busy);
    end
  endtask

  task automatic test_bad_line;
    int ferr0, l, r, f;
    ferr0 = ferr_cnt;
    send_frame(EXP_LN, int'($urandom_range(0, EXP_LN - 1)), EXP_PIX - 1, l, r, f);
    exp_err += CHK_EN;
    n_tests++;
    if (ferr_cnt - ferr0 != CHK_EN) begin
      n_fail++; $display("FAIL bad_line_pulse: got %0d required %0d", ferr_cnt - ferr0, CHK_EN);
    end
    n_tests++;
    if (err_cnt !== 8'(exp_err)) begin
      n_fail++; $display("FAIL bad_line_cnt: got %0d required %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_random_frames;
    int kind, lines, bidx, blen, ferr0, bad, l, r, f;
    for (int it = 0; it < 6; it++) begin
      kind = int'($urandom_range(0, 3));
      lines = EXP_LN; bidx = -1; blen = EXP_PIX;
      case (kind)
        1: begin bidx = int'($urandom_range(0, EXP_LN - 1)); blen = EXP_PIX - 1; end
        2: begin bidx = int'($urandom_range(0, EXP_LN - 1)); blen = EXP_PIX + int'($urandom_range(1, 3)); end
        3: lines = EXP_LN + (($urandom_range(0, 1) == 1) ? 1 : -1);
        default: ;
      endcase
      bad = frame_bad(lines, bidx, blen) ? CHK_EN : 0;
      exp_err += bad;
      ferr0 = ferr_cnt;
      send_frame(lines, bidx, blen, l, r, f);
      n_tests++;
      if (ferr_cnt - ferr0 != bad || err_cnt !== 8'(exp_err)) begin
        n_fail++; $display("FAIL rand_frame%0d kind%0d: got pulses %0d cnt %0d required %0d/%0d",
                           it, kind, ferr_cnt - ferr0, err_cnt, bad, exp_err);
      end
    end
  endtask

  task automatic test_random_capture;
    bit got;
    int n, done0, rise0, lvo0, sum_lv, l, r, f;
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(1, 3));
      done0 = done_cnt; rise0 = fvo_rise_cnt; lvo0 = lvo_hi;
      request(n, got);
      step(2);
      sum_lv = 0;
      for (int k = 0; k <= n; k++) begin
        send_frame(EXP_LN, -1, 0, l, r, f);
        if (k < n) sum_lv += l;
      end
      n_tests++;
      if (!got || fvo_rise_cnt - rise0 != n || done_cnt - done0 != 1 || lvo_hi - lvo0 != sum_lv) begin
        n_fail++; $display("FAIL rand_cap%0d: got ack %b frames %0d done %0d lv %0d required 1/%0d/1/%0d",
                           it, got, fvo_rise_cnt - rise0, done_cnt - done0, lvo_hi - lvo0, n, sum_lv);
      end
    end
  endtask

  task automatic test_midframe_request;
    bit got;
    int rise0, lvo0, done0;
    rise0 = fvo_rise_cnt; lvo0 = lvo_hi; done0 = done_cnt;
    got = 1'b0;
    fork
      begin
        for (int k = 0; k < 2; k++) send_frame(EXP_LN, -1, 0, f_lv[k], f_rise[k], f_fall[k]);
      end
      begin
        step(15);
        request(1, got);
      end
    join
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL mid_ack: got no ack required ack");
    end
    n_tests++;
    if (fvo_rise_cnt - rise0 != 1 || lvo_hi - lvo0 != f_lv[1]) begin
      n_fail++; $display("FAIL mid_gate: got %0d frames %0d lv required 1/%0d",
                         fvo_rise_cnt - rise0, lvo_hi - lvo0, f_lv[1]);
    end
    n_tests++;
    if (last_fvo_rise_cyc - f_rise[1] != 1) begin
      n_fail++; $display("FAIL mid_latency: got %0d required 1", last_fvo_rise_cyc - f_rise[1]);
    end
    n_tests++;
    if (done_cnt - done0 != 1) begin
      n_fail++; $display("FAIL mid_done: got %0d required 1", done_cnt - done0);
    end
  endtask

  task automatic test_pll_drop;
    bit got, seen;
    int done0, rise0, l, r, f;
    request(3, got);
    step(2);
    done0 = done_cnt; rise0 = fvo_rise_cnt;
    seen = 1'b0;
    fork
      send_frame(EXP_LN, -1, 0, l, r, f);
      begin
        for (int i = 0; i < 60 && !seen; i++) begin
          step(1);
          if (fv_out === 1'b1) seen = 1'b1;
        end
        step(5);
        pll = 1'b0;
        step(1);
        n_tests++;
        if (state !== 3'd0 || fv_out !== 1'b0 || cap_io.busy !== 1'b0 || rx_rst_n !== 1'b0) begin
          n_fail++; $display("FAIL pll_drop: got state %0d fv_o %b busy %b rx_rst_n %b required 0/0/0/0",
                             state, fv_out, cap_io.busy, rx_rst_n);
        end
      end
    join
    n_tests++;
    if (!got || !seen) begin
      n_fail++; $display("FAIL pll_drop_setup: got ack %b fv_o %b required 1/1", got, seen);
    end
    n_tests++;
    if (done_cnt != done0 || fvo_rise_cnt - rise0 != 1) begin
      n_fail++; $display("FAIL pll_drop_after: got done %0d frames %0d required 0/1",
                         done_cnt - done0, fvo_rise_cnt - rise0);
    end
  endtask

  task automatic test_fail;
    int entries;
    bit reached;
    logic [2:0] prev;
    pll = 1'b1; enable = 1'b1;
    entries = 0; reached = 1'b0; prev = state;
    for (int i = 0; i < 12000 && !reached; i++) begin
      step(1);
      if (state === 3'd1 && prev !== 3'd1) entries++;
      if (state === 3'd4) reached = 1'b1;
      prev = state;
    end
    n_tests++;
    if (!reached || entries != RETRIES + 1) begin
      n_fail++; $display("FAIL fail_retries: got reached %b resets %0d required 1/%0d",
                         reached, entries, RETRIES + 1);
    end
    step(20);
    n_tests++;
    if (state !== 3'd4 || fail !== 1'b1 || rx_rst_n !== 1'b0 || link_up !== 1'b0) begin
      n_fail++; $display("FAIL fail_hold: got state %0d fail %b rx_rst_n %b required 4/1/0",
                         state, fail, rx_rst_n);
    end
    enable = 1'b0;
    step(1);
    n_tests++;
    if (state !== 3'd0 || fail !== 1'b0) begin
      n_fail++; $display("FAIL fail_exit: got state %0d fail %b required 0/0", state, fail);
    end
  endtask

  initial begin
    test_reset();
    test_link();
    test_capture_basic();
    test_zero_frames();
    test_bad_line();
    test_random_frames();
    test_random_capture();
    test_midframe_request();
    test_pll_drop();
    test_fail();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
